// File: rtl/audio_dac_feeder.sv
// audio_dac_feeder: buffers signed PCM samples in a small FIFO and, once per
// output tick, pops one, attenuates it and feeds the offset-binary word to the
// sigma-delta DAC through a click-free mute/unmute ramp.
// Ports:
//   CLK, RESET (sync, active-low), CEN (divider enable)
//   SAMPLE_IN/SAMPLE_VALID/SAMPLE_READY : sample push handshake (READY = not full)
//   VOL (arith. right shift 0..7), MUTE, CLR_UNDERRUN : controls
//   DAC_DATA, TICK : DAC word and its one-cycle update strobe
//   UNDERRUN (sticky), FIFO_LEVEL : status
module audio_dac_feeder #(
    parameter int IW         = 16,
    parameter int MSBI       = 7,
    parameter int DEPTH_LOG2 = 2,
    parameter int RATE_DIV   = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CEN,
    input  logic [IW-1:0]         SAMPLE_IN,
    input  logic                  SAMPLE_VALID,
    output logic                  SAMPLE_READY,
    input  logic [2:0]            VOL,
    input  logic                  MUTE,
    input  logic                  CLR_UNDERRUN,
    output logic [MSBI:0]         DAC_DATA,
    output logic                  TICK,
    output logic                  UNDERRUN,
    output logic [DEPTH_LOG2:0]   FIFO_LEVEL
);
    localparam int CW = $clog2(RATE_DIV);
    localparam int DN = 2 ** DEPTH_LOG2;
    localparam int SH = IW - MSBI - 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RATE_DIV - 1);
    localparam logic [CW-1:0] C1 = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] P1 = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0] L1 = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [MSBI:0] MID = {1'b1, {MSBI{1'b0}}};
    localparam logic [MSBI:0] W1 = (MSBI + 1)'(1);

    typedef enum logic [1:0] {S_RUN, S_RAMP_DN, S_MUTED, S_RAMP_UP} state_t;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [IW-1:0]         mem_q [DN];
    logic [MSBI:0]         cur_q, cur_d, dac_q, dac_d, word;
    logic                  tick_q, underrun_q, underrun_d;
    logic                  tick, push, pop;
    state_t                state_q, state_d, eff;

    function automatic logic [MSBI:0] step_to(input logic [MSBI:0] a, input logic [MSBI:0] b);
        return a < b ? a + W1 : a > b ? a - W1 : a;
    endfunction

    assign SAMPLE_READY = level_q != DEPTH;
    assign FIFO_LEVEL   = level_q;
    assign DAC_DATA     = dac_q;
    assign TICK         = tick_q;
    assign UNDERRUN     = underrun_q;

    always_comb begin
        tick    = CEN && cnt_q == CNT_MAX;
        cnt_d   = !CEN ? cnt_q : tick ? '0 : cnt_q + C1;
        push    = SAMPLE_VALID && SAMPLE_READY;
        // level_q is registered, so a sample pushed on a tick cycle is not visible to that tick
        pop     = tick && level_q != '0;
        wr_d    = push ? wr_q + P1 : wr_q;
        rd_d    = pop ? rd_q + P1 : rd_q;
        level_d = (push && !pop) ? level_q + L1 : (pop && !push) ? level_q - L1 : level_q;
        // attenuation shift and top-bit selection folded into one arithmetic shift
        word    = (MSBI + 1)'($signed(mem_q[rd_q]) >>> (32'(VOL) + SH));
        cur_d   = pop ? {~word[MSBI], word[MSBI-1:0]} : cur_q;
        underrun_d = (tick && level_q == '0) || (underrun_q && !CLR_UNDERRUN);
    end

    // MUTE changes redirect the ramp on the same tick the step is taken
    always_comb begin
        eff = (MUTE && (state_q == S_RUN || state_q == S_RAMP_UP)) ? S_RAMP_DN :
              (!MUTE && (state_q == S_RAMP_DN || state_q == S_MUTED)) ? S_RAMP_UP : state_q;
        state_d = state_q;
        dac_d   = dac_q;
        if (tick) begin
            case (eff)
                S_RUN:   dac_d = cur_d;
                S_MUTED: dac_d = MID;
                S_RAMP_DN: begin
                    dac_d   = step_to(dac_q, MID);
                    state_d = dac_d == MID ? S_MUTED : S_RAMP_DN;
                end
                default: begin
                    dac_d   = step_to(dac_q, cur_d);
                    state_d = dac_d == cur_d ? S_RUN : S_RAMP_UP;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= SAMPLE_IN;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            cur_q      <= MID;
            dac_q      <= MID;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            state_q    <= S_MUTED;
        end else begin
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            cur_q      <= cur_d;
            dac_q      <= dac_d;
            tick_q     <= tick;
            underrun_q <= underrun_d;
            state_q    <= state_d;
        end
    end
endmodule

// File: tb/tb_audio_dac_feeder.sv
// tb_audio_dac_feeder: directed stimulus with a DAC_DATA scoreboard checked on every TICK.
module tb_audio_dac_feeder;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        CEN = 1'b0;
    logic [15:0] SAMPLE_IN = '0;
    logic        SAMPLE_VALID = 1'b0;
    logic        SAMPLE_READY;
    logic [2:0]  VOL = '0;
    logic        MUTE = 1'b0;
    logic        CLR_UNDERRUN = 1'b0;
    logic [7:0]  DAC_DATA;
    logic        TICK;
    logic        UNDERRUN;
    logic [2:0]  FIFO_LEVEL;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    audio_dac_feeder #(.IW(16), .MSBI(7), .DEPTH_LOG2(2), .RATE_DIV(RD)) dut (
        .CLK(clk), .RESET(RESET), .CEN(CEN), .SAMPLE_IN(SAMPLE_IN),
        .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_READY(SAMPLE_READY), .VOL(VOL),
        .MUTE(MUTE), .CLR_UNDERRUN(CLR_UNDERRUN), .DAC_DATA(DAC_DATA),
        .TICK(TICK), .UNDERRUN(UNDERRUN), .FIFO_LEVEL(FIFO_LEVEL)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            #2;
            if (TICK) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tick: got dac %0h, want no tick", DAC_DATA);
                end else begin
                    chk("dac_at_tick", {24'b0, DAC_DATA}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    endtask

    task automatic push(input logic [15:0] s);
        SAMPLE_IN = s;
        SAMPLE_VALID = 1'b1;
        @(negedge clk);
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic clr_pulse();
        CLR_UNDERRUN = 1'b1;
        @(negedge clk);
        CLR_UNDERRUN = 1'b0;
    endtask

    // Runs the divider for exactly one tick; optional push/clear land on the tick edge.
    task automatic tick_ex(input logic [7:0] exp, input bit do_push, input logic [15:0] s, input bit clr);
        int n;
        exp_q.push_back(exp);
        CEN = 1'b1;
        repeat (RD - 1) @(negedge clk);
        if (do_push) begin
            SAMPLE_IN = s;
            SAMPLE_VALID = 1'b1;
        end
        CLR_UNDERRUN = clr;
        @(negedge clk);
        SAMPLE_VALID = 1'b0;
        CLR_UNDERRUN = 1'b0;
        n = 0;
        while (!TICK && n < 8) begin
            @(negedge clk);
            n++;
        end
        CEN = 1'b0;
        chk("tick_arrived", {31'b0, TICK}, 32'd1);
    endtask

    task automatic tick(input logic [7:0] exp);
        tick_ex(exp, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        chk("rst_level", {29'b0, FIFO_LEVEL}, 32'd0);
        chk("rst_ready", {31'b0, SAMPLE_READY}, 32'd1);
        chk("rst_dac", {24'b0, DAC_DATA}, 32'h80);
        chk("rst_tick", {31'b0, TICK}, 32'd0);
        chk("rst_underrun", {31'b0, UNDERRUN}, 32'd0);

        push(16'h7FFF);
        chk("level_after_push", {29'b0, FIFO_LEVEL}, 32'd1);
        for (int v = 8'h81; v <= 8'hFF; v++) tick(8'(v));
        chk("underrun_after_ramp", {31'b0, UNDERRUN}, 32'd1);
        @(negedge clk);
        chk("tick_one_cycle", {31'b0, TICK}, 32'd0);
        chk("dac_hold", {24'b0, DAC_DATA}, 32'hFF);

        push(16'h8000);
        push(16'h0000);
        chk("level_two", {29'b0, FIFO_LEVEL}, 32'd2);
        tick(8'h00);
        tick(8'h80);
        VOL = 3'd7;
        push(16'h8000);
        tick(8'h7F);
        VOL = 3'd0;
        clr_pulse();
        chk("underrun_cleared", {31'b0, UNDERRUN}, 32'd0);

        push(16'h4000);
        push(16'h2000);
        push(16'h1000);
        push(16'h0800);
        chk("full_level", {29'b0, FIFO_LEVEL}, 32'd4);
        chk("full_ready", {31'b0, SAMPLE_READY}, 32'd0);
        push(16'h7FFF);
        chk("full_reject_level", {29'b0, FIFO_LEVEL}, 32'd4);
        tick(8'hC0);
        chk("after_pop_level", {29'b0, FIFO_LEVEL}, 32'd3);
        chk("after_pop_ready", {31'b0, SAMPLE_READY}, 32'd1);
        tick(8'hA0);
        tick(8'h90);
        tick(8'h88);
        chk("no_underrun_yet", {31'b0, UNDERRUN}, 32'd0);
        tick(8'h88);
        chk("underrun_set", {31'b0, UNDERRUN}, 32'd1);
        tick_ex(8'h88, 1'b0, 16'h0, 1'b1);
        chk("underrun_set_wins", {31'b0, UNDERRUN}, 32'd1);
        clr_pulse();
        chk("underrun_clr", {31'b0, UNDERRUN}, 32'd0);
        tick_ex(8'h88, 1'b1, 16'h4000, 1'b0);
        chk("no_fallthrough_underrun", {31'b0, UNDERRUN}, 32'd1);
        chk("no_fallthrough_level", {29'b0, FIFO_LEVEL}, 32'd1);
        tick(8'hC0);
        chk("drained_level", {29'b0, FIFO_LEVEL}, 32'd0);

        MUTE = 1'b1;
        for (int v = 8'hBF; v >= 8'h80; v--) tick(8'(v));
        tick(8'h80);
        MUTE = 1'b0;
        for (int v = 8'h81; v <= 8'hC0; v++) tick(8'(v));
        MUTE = 1'b1;
        for (int v = 8'hBF; v >= 8'hA0; v--) tick(8'(v));
        MUTE = 1'b0;
        for (int v = 8'hA1; v <= 8'hA4; v++) tick(8'(v));

        push(16'h1234);
        push(16'h5678);
        chk("pre_reset_level", {29'b0, FIFO_LEVEL}, 32'd2);
        chk("pre_reset_underrun", {31'b0, UNDERRUN}, 32'd1);
        CEN = 1'b1;
        repeat (RD - 1) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", {29'b0, FIFO_LEVEL}, 32'd0);
        chk("mid_rst_ready", {31'b0, SAMPLE_READY}, 32'd1);
        chk("mid_rst_dac", {24'b0, DAC_DATA}, 32'h80);
        chk("mid_rst_underrun", {31'b0, UNDERRUN}, 32'd0);
        chk("mid_rst_tick", {31'b0, TICK}, 32'd0);
        RESET = 1'b1;
        CEN = 1'b0;
        @(negedge clk);
        tick(8'h80);
        chk("post_rst_discarded", {31'b0, UNDERRUN}, 32'd1);
        push(16'h7FFF);
        tick(8'hFF);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
